pushbtn_poller: RTL and testbench
=================================

# pushbtn_poller

Polling controller that sits directly upstream of the PushBtn peripheral. It periodically issues `PushBtn_RBS` on PushBtn's instruction port and samples the returned `button_status`. Each sampled press becomes a one-cycle `press` event and increments a saturating press counter. The block takes its own 12-bit instruction stream from the system controller, in the same {4-bit opcode, 8-bit immediate} format and with the same error-state discipline as the other peripherals.

## Interface
- `PollWait`, 100, cycles spent in Wait between polls; must be ≥ 1.
- `PollSize`, 7, width of the poll-interval counter; must be able to hold `PollWait-1`.
- `CountSize`, 8, width of the press counter.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst`  in  12  [11:8] opcode, [7:0] immediate (ignored by all opcodes).
- `inst_en`  in  1  `inst` is executed on every edge where this is 1.
- `pb_inst`  out  12  instruction to PushBtn; immediate always 8'h00.
- `pb_inst_en`  out  1  instruction enable to PushBtn.
- `pb_status`  in  1  PushBtn `button_status`.
- `press`  out  1  one-cycle pulse per sampled press.
- `count`  out  CountSize  press counter, saturating.
- `error`  out  1  high while in the Error state.

## Operation
- Opcodes:
  - 4'h0 NOP: no effect.
  - 4'h1 CLR: `count` := 0.
  - 4'h2 ENA: enable polling.
  - 4'h3 DIS: disable polling.
  - Any other opcode with `inst_en`=1: enter Error.
- Instructions are executed in every state except Error.
- FSM states: Wait, Issue, Sample, Error. Reset state is Wait, with polling enabled and the interval counter loaded with `PollWait-1`.
- Wait:
  - `pb_inst`={`PushBtn_NOP`,8'h00}, `pb_inst_en`=0.
  - Enabled and counter≠0: decrement the counter.
  - Enabled and counter=0: go to Issue.
  - Disabled: reload the counter to `PollWait-1` and hold it there.
- Issue (exactly 1 cycle):
  - `pb_inst`={`PushBtn_RBS`,8'h00}, `pb_inst_en`=1.
  - Next state is Sample.
- Sample (exactly 1 cycle):
  - `pb_inst`={`PushBtn_NOP`,8'h00}, `pb_inst_en`=0.
  - `pb_status` is sampled at the end of this cycle.
  - If `pb_status`=1: `press`=1 on the next cycle, and `count` increments unless it is all-ones.
  - Next state is Wait, with the counter reloaded to `PollWait-1`.
- Error:
  - `error`=1, `pb_inst`={`PushBtn_NOP`,8'h00}, `pb_inst_en`=0, `press`=0.
  - `count` is frozen and all instructions are ignored.
  - The only exit is `reset`.
- Boundary rules:
  - CLR on the same edge as an increment: `count`=0 (CLR wins) and `press` still pulses.
  - DIS during Issue or Sample: the in-flight poll completes and is counted; the block then holds in Wait.
  - ENA while enabled, or DIS while disabled: no effect.
  - `count` saturates at 2^CountSize-1 and never wraps. `press` still pulses at saturation.
  - Invalid opcode during Issue or Sample: Error on the next edge. The pending sample is discarded.
  - Reset asserted mid-poll: every output returns to its reset value immediately (asynchronous).

## Timing
- Reset values:
  - `pb_inst`={`PushBtn_NOP`,8'h00}
  - `pb_inst_en`=0, `press`=0, `count`=0, `error`=0
- PushBtn contract: `button_status` is valid on the cycle after the edge that executes RBS. Sample therefore reads it with 1 cycle of latency.
- First Issue cycle begins `PollWait` cycles after reset deasserts.
- Poll period while enabled: `PollWait+2` cycles, measured from one `pb_inst_en` rising to the next.
- Latency from the Sample edge to `press`/`count` update: 1 edge. Both change on the same edge.
- Instruction effects (CLR, ENA, DIS, error) are visible 1 edge after the edge where `inst_en`=1 is sampled.
- `pb_inst_en` is high for exactly 1 cycle per poll, never 2 consecutive cycles.

## Test plan
- Reset, then `pb_status`=0 with `PollWait`=50:
  - `pb_inst_en` pulses for 1 cycle every 52 cycles, carrying `pb_inst`=`PushBtn_RBS`.
  - `count`=0, `press` never asserts.
- `pb_status`=1 during one Sample cycle only:
  - Exactly one `press` pulse, the cycle after that Sample.
  - `count` goes 0→1; later polls with status 0 leave it at 1.
- `CountSize`=2, `pb_status` held at 1 for 5 polls:
  - `count` goes 1,2,3,3,3.
  - `press` pulses 5 times.
- CLR issued on the same edge as an incrementing Sample:
  - `count`=0 and `press`=1 on the next cycle.
- DIS issued during Issue:
  - That poll is counted.
  - No further `pb_inst_en` until ENA; after ENA, the first Issue comes exactly `PollWait` cycles later.
- Opcode 4'hB with imm 8'hAE:
  - `error`=1 and `pb_inst_en` stays 0.
  - A following CLR is ignored and `count` is unchanged.
  - After a `reset` pulse, all outputs return to reset values and polling resumes.

Source files
------------

// File: rtl/pushbtn_poller.sv
// pushbtn_poller: periodically issues RBS to the PushBtn peripheral, samples
// button_status one cycle later, and turns each sampled press into a one-cycle
// press pulse plus a saturating press count. Executes its own 12-bit
// {opcode, imm} instruction stream; an unknown opcode locks it in Error.
module pushbtn_poller #(
  parameter int unsigned PollWait  = 100,
  parameter int unsigned PollSize  = 7,
  parameter int unsigned CountSize = 8,
  parameter logic [3:0]  PbOpNop   = 4'h0,  // PushBtn_NOP
  parameter logic [3:0]  PbOpRbs   = 4'h1   // PushBtn_RBS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          inst,
  input  logic                 inst_en,
  output logic [11:0]          pb_inst,
  output logic                 pb_inst_en,
  input  logic                 pb_status,
  output logic                 press,
  output logic [CountSize-1:0] count,
  output logic                 error
);

  typedef enum logic [1:0] {StWait, StIssue, StSample, StError} state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpClr = 4'h1;
  localparam logic [3:0] OpEna = 4'h2;
  localparam logic [3:0] OpDis = 4'h3;

  localparam logic [PollSize-1:0]  PollReload = PollSize'(PollWait - 1);
  localparam logic [CountSize-1:0] CountMax   = '1;

  state_e               state_q, state_d;
  logic [PollSize-1:0]  poll_cnt_q, poll_cnt_d;
  logic                 enabled_q, enabled_d;
  logic                 press_q, press_d;
  logic [CountSize-1:0] count_q, count_d;
  logic [3:0]           pb_op;

  logic [3:0] op;
  logic       inst_clr, inst_ena, inst_dis, inst_bad;

  // The immediate field carries no meaning for any opcode.
  logic unused_imm;
  assign unused_imm = ^inst[7:0];

  // Instruction decode; NOP is any valid opcode with no side effect.
  always_comb begin
    op       = inst[11:8];
    inst_clr = inst_en && (op == OpClr);
    inst_ena = inst_en && (op == OpEna);
    inst_dis = inst_en && (op == OpDis);
    inst_bad = inst_en && (op != OpNop) && (op != OpClr) && (op != OpEna) && (op != OpDis);
  end

  // Poll sequencing, sample handling and instruction execution.
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    enabled_d  = enabled_q;
    press_d    = 1'b0;
    count_d    = count_q;
    pb_op      = PbOpNop;
    pb_inst_en = 1'b0;
    error      = 1'b0;

    unique case (state_q)
      StWait: begin
        if (!enabled_q) begin
          poll_cnt_d = PollReload;
        end else if (poll_cnt_q != '0) begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        pb_op      = PbOpRbs;
        pb_inst_en = 1'b1;
        state_d    = StSample;
      end
      StSample: begin
        // The in-flight poll always completes, even if DIS arrived meanwhile.
        state_d    = StWait;
        poll_cnt_d = PollReload;
        press_d    = pb_status;
        if (pb_status && (count_q != CountMax)) begin
          count_d = count_q + 1'b1;
        end
      end
      StError: begin
        error = 1'b1;
      end
      default: begin
        state_d = StError;
      end
    endcase

    if (state_q != StError) begin
      if (inst_bad) begin
        // Discard any pending sample.
        state_d = StError;
        press_d = 1'b0;
        count_d = count_q;
      end else begin
        if (inst_clr) count_d = '0;  // CLR beats a simultaneous increment
        if (inst_ena) enabled_d = 1'b1;
        if (inst_dis) enabled_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StWait;
      poll_cnt_q <= PollReload;
      enabled_q  <= 1'b1;
      press_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      enabled_q  <= enabled_d;
      press_q    <= press_d;
      count_q    <= count_d;
    end
  end

  assign pb_inst = {pb_op, 8'h00};
  assign press   = press_q;
  assign count   = count_q;

endmodule

// File: tb/tb_pushbtn_poller.sv
// Bench for pushbtn_poller: a timeline model (cycle index of the next RBS
// issue, enable flag, error flag, count) checked every cycle, plus
// hand-computed literal checks at known cycles. Issue cycles after reset
// fall at 50 + 52*n, sample cycles at 51 + 52*n.
module tb_pushbtn_poller;

  localparam int PW   = 50;
  localparam int CS   = 2;
  localparam int CMAX = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   inst = 12'h000;
  logic          inst_en = 1'b0;
  logic          pb_status = 1'b0;
  logic [11:0]   pb_inst;
  logic          pb_inst_en;
  logic          press;
  logic [CS-1:0] count;
  logic          error;

  int total = 0;
  int bad   = 0;

  // Model state: k is the index of the current cycle since reset release.
  int k        = 0;
  int issue_at = PW;
  int m_count  = 0;
  bit m_en     = 1'b1;
  bit m_err    = 1'b0;
  bit m_press  = 1'b0;

  pushbtn_poller #(
    .PollWait (PW),
    .PollSize (7),
    .CountSize(CS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .inst      (inst),
    .inst_en   (inst_en),
    .pb_inst   (pb_inst),
    .pb_inst_en(pb_inst_en),
    .pb_status (pb_status),
    .press     (press),
    .count     (count),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // Advance the model over the edge that ends cycle k.
  task automatic model_step();
    logic [3:0] op;
    bit is_issue, is_sample;
    op        = inst[11:8];
    is_issue  = (k == issue_at);
    is_sample = (k == issue_at + 1);
    if (!m_err) begin
      if (inst_en && op > 4'h3) begin
        m_err   = 1'b1;
        m_press = 1'b0;
      end else begin
        m_press = is_sample && pb_status;
        if (inst_en && op == 4'h1) m_count = 0;
        else if (m_press && m_count < CMAX) m_count++;
        if (is_sample) issue_at = k + 1 + PW;
        else if (!is_issue && !m_en) issue_at = k + 1 + PW;
        if (inst_en && op == 4'h2) m_en = 1'b1;
        if (inst_en && op == 4'h3) m_en = 1'b0;
      end
    end
    k++;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      k = 0; issue_at = PW; m_count = 0; m_en = 1'b1; m_err = 1'b0; m_press = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    bit exp_en;
    @(negedge clock);
    exp_en = !m_err && (k == issue_at);
    chk("pb_inst_en", int'(pb_inst_en), int'(exp_en));
    chk("pb_inst", int'(pb_inst), exp_en ? 32'h100 : 32'h000);
    chk("press", int'(press), int'(m_press));
    chk("count", int'(count), m_count);
    chk("error", int'(error), int'(m_err));
  end

  // Wait until cycle n has started (1 time unit after its opening edge).
  task automatic goto(input int n);
    int g = 0;
    while (k < n && g < 3000) begin
      @(posedge clock);
      #1;
      g++;
    end
    if (k != n) begin
      total++;
      bad++;
      $display("FAIL goto: reached cycle %0d, required %0d", k, n);
    end
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_pb_inst_en", int'(pb_inst_en), 0);
    chk("rst_press", int'(press), 0);
    chk("rst_pb_inst", int'(pb_inst), 32'h000);

    // Idle polling with status 0: first issue at cycle 50, period 52.
    goto(49);  chk("pre_first_issue", int'(pb_inst_en), 0);
    goto(50);  chk("first_issue", int'(pb_inst_en), 1);
    chk("first_issue_inst", int'(pb_inst), 32'h100);
    goto(51);  chk("issue_one_cycle", int'(pb_inst_en), 0);
    goto(101); chk("pre_second_issue", int'(pb_inst_en), 0);
    goto(102); chk("second_issue", int'(pb_inst_en), 1);

    // One press at sample cycle 103.
    goto(103); pb_status = 1'b1;
    goto(104); pb_status = 1'b0;
    chk("press_once", int'(press), 1);
    chk("count_one", int'(count), 1);
    goto(105); chk("press_ends", int'(press), 0);
    goto(156); chk("count_holds", int'(count), 1);

    // CLR, then saturation with status held through samples 207..415.
    goto(180); inst = 12'h100; inst_en = 1'b1;
    goto(181); inst_en = 1'b0;
    goto(182); chk("clr_count", int'(count), 0);
    goto(200); pb_status = 1'b1;
    goto(208); chk("sat_1", int'(count), 1);
    goto(260); chk("sat_2", int'(count), 2);
    goto(312); chk("sat_3", int'(count), 3);
    goto(364); chk("sat_4", int'(count), 3);
    goto(416); chk("sat_5", int'(count), 3);
    chk("sat_press", int'(press), 1);
    pb_status = 1'b0;

    // CLR on the same edge as an incrementing sample (467).
    goto(467); pb_status = 1'b1; inst = 12'h1A5; inst_en = 1'b1;
    goto(468); pb_status = 1'b0; inst_en = 1'b0;
    chk("clr_wins_count", int'(count), 0);
    chk("clr_wins_press", int'(press), 1);

    // DIS during issue 518: that poll still counts, then polling stops.
    goto(518); inst = 12'h300; inst_en = 1'b1;
    goto(519); inst_en = 1'b0; pb_status = 1'b1;
    goto(520); pb_status = 1'b0;
    chk("dis_counted", int'(count), 1);
    chk("dis_press", int'(press), 1);
    goto(570); chk("dis_no_issue", int'(pb_inst_en), 0);
    goto(700); chk("dis_count_hold", int'(count), 1);
    inst = 12'h200; inst_en = 1'b1;
    goto(701); inst_en = 1'b0;
    goto(750); chk("ena_pre_issue", int'(pb_inst_en), 0);
    goto(751); chk("ena_issue", int'(pb_inst_en), 1);

    // Invalid opcode: error, later CLR ignored.
    goto(760); inst = 12'hBAE; inst_en = 1'b1;
    goto(761); inst_en = 1'b0;
    chk("err_set", int'(error), 1);
    goto(770); inst = 12'h100; inst_en = 1'b1;
    goto(771); inst_en = 1'b0;
    goto(772); chk("err_clr_ignored", int'(count), 1);
    goto(803); chk("err_no_issue", int'(pb_inst_en), 0);

    // Asynchronous reset mid-cycle, then polling resumes.
    goto(820);
    #2 reset = 1'b1;
    #1;
    chk("areset_error", int'(error), 0);
    chk("areset_count", int'(count), 0);
    chk("areset_press", int'(press), 0);
    @(negedge clock);
    #1 reset = 1'b0;
    goto(50); chk("resume_issue", int'(pb_inst_en), 1);

    // Invalid opcode during sample discards the pending press.
    goto(51); pb_status = 1'b1; inst = 12'hF00; inst_en = 1'b1;
    goto(52); pb_status = 1'b0; inst_en = 1'b0;
    chk("bad_in_sample_err", int'(error), 1);
    chk("bad_in_sample_press", int'(press), 0);
    chk("bad_in_sample_count", int'(count), 0);
    goto(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
